lcd_pic_loader: RTL and testbench

Writer side of the LCD picture image RAM: accepts an RGB888 byte stream over a valid/ready handshake, packs three bytes into one 24-bit pixel and writes it into the image block RAM, raster order from address 0. The LCD pixel renderer reads the same RAM on its other port. The renderer addresses the RAM as `(y - ORIGIN_Y) * IMG_WIDTH + (x - ORIGIN_X)`, and this block fills it in exactly that order.

---
 rtl/lcd_pic_loader.sv | 184 ++++++++++++++++++
 tb/tb_lcd_pic_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pic_loader.sv
// Packs an RGB888 byte stream into 24-bit pixels and writes them to the image RAM in raster order.
// Optional trailing-checksum verification is enabled by defining LCD_PIC_LOADER_CKSUM_EN.
module lcd_pic_loader #(
    parameter int IMG_WIDTH  = 345,
    parameter int IMG_HEIGHT = 249,
    parameter int ADDR_W     = 17
) (
    input  logic              clk_in,
    input  logic              sys_rst,
    input  logic              frame_start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [23:0]       ram_din,
    output logic              busy,
    output logic              frame_done,
    output logic              cksum_err
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] PIX_ONE  = ADDR_W'(1);

`ifdef LCD_PIC_LOADER_CKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DONE  = 2'd2,
        ST_CKSUM = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`endif

    state_t             state_reg;
    state_t             state_next;
    logic [1:0]         byte_idx_reg;
    logic [7:0]         r_reg;
    logic [7:0]         g_reg;
    logic [ADDR_W-1:0]  pix_cnt_reg;
    logic               ram_we_reg;
    logic [ADDR_W-1:0]  ram_addr_reg;
    logic [23:0]        ram_din_reg;

    logic               ready_comb;
    logic               busy_comb;
    logic               done_comb;
    logic               frame_clear;
    logic               byte_accept;
    logic               pix_byte;
    logic               pix_last_byte;

    // frame_start while receiving both restarts the frame and masks s_ready,
    // so a byte offered in that cycle is never consumed.
    always_comb begin
        state_next  = state_reg;
        ready_comb  = 1'b0;
        busy_comb   = 1'b0;
        done_comb   = 1'b0;
        frame_clear = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (frame_start) begin
                    frame_clear = 1'b1;
                    state_next  = ST_RECV;
                end
            end
            ST_RECV: begin
                busy_comb = 1'b1;
                if (frame_start) begin
                    frame_clear = 1'b1;
                end else begin
                    ready_comb = 1'b1;
                    if (s_valid && (byte_idx_reg == 2'd2) && (pix_cnt_reg == LAST_PIX)) begin
`ifdef LCD_PIC_LOADER_CKSUM_EN
                        state_next = ST_CKSUM;
`else
                        state_next = ST_DONE;
`endif
                    end
                end
            end
`ifdef LCD_PIC_LOADER_CKSUM_EN
            ST_CKSUM: begin
                busy_comb = 1'b1;
                if (frame_start) begin
                    frame_clear = 1'b1;
                    state_next  = ST_RECV;
                end else begin
                    ready_comb = 1'b1;
                    if (s_valid) begin
                        state_next = ST_DONE;
                    end
                end
            end
`endif
            ST_DONE: begin
                done_comb  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign byte_accept   = s_valid && ready_comb;
    assign pix_byte      = byte_accept && (state_reg == ST_RECV);
    assign pix_last_byte = pix_byte && (byte_idx_reg == 2'd2);

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            state_reg    <= ST_IDLE;
            byte_idx_reg <= 2'd0;
            r_reg        <= 8'd0;
            g_reg        <= 8'd0;
            pix_cnt_reg  <= '0;
            ram_we_reg   <= 1'b0;
            ram_addr_reg <= '0;
            ram_din_reg  <= 24'd0;
        end else begin
            state_reg  <= state_next;
            ram_we_reg <= pix_last_byte;
            if (pix_last_byte) begin
                ram_addr_reg <= pix_cnt_reg;
                ram_din_reg  <= {r_reg, g_reg, s_data};
            end
            if (frame_clear) begin
                byte_idx_reg <= 2'd0;
                pix_cnt_reg  <= '0;
            end else if (pix_byte) begin
                case (byte_idx_reg)
                    2'd0:    r_reg <= s_data;
                    2'd1:    g_reg <= s_data;
                    default: pix_cnt_reg <= pix_cnt_reg + PIX_ONE;
                endcase
                byte_idx_reg <= (byte_idx_reg == 2'd2) ? 2'd0 : byte_idx_reg + 2'd1;
            end
        end
    end

`ifdef LCD_PIC_LOADER_CKSUM_EN
    logic [7:0] sum_reg;
    logic       cksum_err_reg;
    logic       ck_byte;

    assign ck_byte = byte_accept && (state_reg == ST_CKSUM);

    // The error flag is sticky: only a new frame or reset clears it.
    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            sum_reg       <= 8'd0;
            cksum_err_reg <= 1'b0;
        end else if (frame_clear) begin
            sum_reg       <= 8'd0;
            cksum_err_reg <= 1'b0;
        end else begin
            if (pix_byte) begin
                sum_reg <= sum_reg + s_data;
            end
            if (ck_byte) begin
                cksum_err_reg <= cksum_err_reg | (s_data != sum_reg);
            end
        end
    end

    assign cksum_err = cksum_err_reg;
`else
    assign cksum_err = 1'b0;
`endif

    assign s_ready    = ready_comb;
    assign busy       = busy_comb;
    assign frame_done = done_comb;
    assign ram_we     = ram_we_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_din    = ram_din_reg;

endmodule

// File: tb/tb_lcd_pic_loader.sv
// Directed bench for lcd_pic_loader on a reduced 40x30 image; follows LCD_PIC_LOADER_CKSUM_EN if defined.
module tb_lcd_pic_loader;

    localparam int W     = 40;
    localparam int H     = 30;
    localparam int AW    = 11;
    localparam int TOTAL = W * H;
`ifdef LCD_PIC_LOADER_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          sys_rst;
    logic          frame_start;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [23:0]   ram_din;
    logic          busy;
    logic          frame_done;
    logic          cksum_err;

    int            n_total = 0;
    int            n_bad   = 0;
    int            wr_cnt  = 0;
    int            done_cnt = 0;
    int            exp_addr = 0;
    logic [23:0]   exp_q[$];
    logic [23:0]   pix_acc = 24'd0;
    int            byte_idx = 0;
    logic [7:0]    sum = 8'd0;

    lcd_pic_loader #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .ADDR_W    (AW)
    ) dut (
        .clk_in     (clk_in),
        .sys_rst    (sys_rst),
        .frame_start(frame_start),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .busy       (busy),
        .frame_done (frame_done),
        .cksum_err  (cksum_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // RAM write monitor: every write must match the next queued pixel at the next address.
    always @(negedge clk_in) begin
        logic [23:0] want;
        if (ram_we) begin
            check("wr_addr", 32'(ram_addr), 32'(exp_addr));
            check("wr_q_depth", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check("wr_data", 32'(ram_din), 32'(want));
            end
            exp_addr++;
            wr_cnt++;
        end
        if (frame_done) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit pix);
        int guard;
        s_valid = 1'b1;
        s_data  = b;
        #1;
        guard = 0;
        while (!s_ready && guard < 64) begin
            @(posedge clk_in);
            #2;
            guard++;
        end
        if (guard >= 64) check("ready_timeout", 32'(s_ready), 32'd1);
        @(posedge clk_in);
        #1;
        s_valid = 1'b0;
        if (pix) begin
            sum     = sum + b;
            pix_acc = {pix_acc[15:0], b};
            byte_idx++;
            if (byte_idx == 3) begin
                exp_q.push_back(pix_acc);
                byte_idx = 0;
            end
        end
    endtask

    task automatic send_pixel(input logic [23:0] p, input bit gaps);
        for (int k = 0; k < 3; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk_in);
                #1;
            end
            send_byte(p[23 - 8*k -: 8], 1'b1);
        end
    endtask

    task automatic do_frame_start(input bit offer_byte);
        frame_start = 1'b1;
        if (offer_byte) begin
            s_valid = 1'b1;
            s_data  = 8'h5A;
        end
        #1;
        check("fs_ready_masked", 32'(s_ready), 32'd0);
        @(posedge clk_in);
        #1;
        frame_start = 1'b0;
        s_valid     = 1'b0;
        exp_q.delete();
        exp_addr = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        byte_idx = 0;
        sum      = 8'd0;
        #1;
        check("fs_ready", 32'(s_ready), 32'd1);
        check("fs_busy", 32'(busy), 32'd1);
        check("fs_cksum_err", 32'(cksum_err), 32'd0);
    endtask

    task automatic finish_frame(input bit bad);
        check("last_we", 32'(ram_we), 32'd1);
        check("last_addr", 32'(ram_addr), 32'(TOTAL - 1));
`ifdef LCD_PIC_LOADER_CKSUM_EN
        check("ck_no_done_yet", 32'(frame_done), 32'd0);
        check("ck_busy", 32'(busy), 32'd1);
        check("ck_ready", 32'(s_ready), 32'd1);
        send_byte(sum ^ 8'(bad), 1'b0);
        check("ck_err", 32'(cksum_err), 32'(bad));
`endif
        check("done_pulse", 32'(frame_done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_ready", 32'(s_ready), 32'd0);
        @(posedge clk_in);
        #1;
        check("post_done_pulse", 32'(frame_done), 32'd0);
        check("post_done_ready", 32'(s_ready), 32'd0);
        check("post_done_busy", 32'(busy), 32'd0);
        check("post_done_err", 32'(cksum_err), 32'(CK_EN & bad));
        check("frame_wr_cnt", 32'(wr_cnt), 32'(TOTAL));
        check("frame_done_cnt", 32'(done_cnt), 32'd1);
        check("frame_q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_s_ready"}, 32'(s_ready), 32'd0);
        check({phase, "_ram_we"}, 32'(ram_we), 32'd0);
        check({phase, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({phase, "_ram_din"}, 32'(ram_din), 32'd0);
        check({phase, "_busy"}, 32'(busy), 32'd0);
        check({phase, "_frame_done"}, 32'(frame_done), 32'd0);
        check({phase, "_cksum_err"}, 32'(cksum_err), 32'd0);
    endtask

    initial begin
        sys_rst     = 1'b1;
        frame_start = 1'b0;
        s_valid     = 1'b0;
        s_data      = 8'd0;
        repeat (3) @(posedge clk_in);
        #1;
        sys_rst = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        check_reset_outputs("rst");
        $display("tb: reset and idle outputs checked");

        do_frame_start(1'b0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        check("px0_we", 32'(ram_we), 32'd1);
        check("px0_addr", 32'(ram_addr), 32'd0);
        check("px0_din", 32'(ram_din), 32'h123456);
        send_byte(8'hAB, 1'b1);
        check("hold_we", 32'(ram_we), 32'd0);
        check("hold_addr", 32'(ram_addr), 32'd0);
        check("hold_din", 32'(ram_din), 32'h123456);
        send_byte(8'hCD, 1'b1);
        send_byte(8'hEF, 1'b1);
        check("px1_we", 32'(ram_we), 32'd1);
        check("px1_addr", 32'(ram_addr), 32'd1);
        check("px1_din", 32'(ram_din), 32'hABCDEF);
        $display("tb: two directed pixels written");

        for (int i = 2; i < TOTAL; i++) send_pixel(24'($urandom), 1'b1);
        finish_frame(1'b0);
        $display("tb: full frame of %0d pixels with gaps, checksum good", TOTAL);

        s_valid = 1'b1;
        s_data  = 8'hFF;
        repeat (4) begin
            #1;
            check("idle_ready", 32'(s_ready), 32'd0);
            @(posedge clk_in);
            #1;
        end
        s_valid = 1'b0;
        check("idle_no_write", 32'(wr_cnt), 32'(TOTAL));
        $display("tb: excess bytes refused in idle");

        do_frame_start(1'b0);
        for (int i = 0; i < 1000; i++) send_pixel(24'($urandom), 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        repeat (2) @(posedge clk_in);
        #1;
        check("abort_wr_cnt", 32'(wr_cnt), 32'd1000);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        do_frame_start(1'b1);
        send_pixel(24'hC0FFEE, 1'b0);
        check("restart_addr", 32'(ram_addr), 32'd0);
        check("restart_din", 32'(ram_din), 32'hC0FFEE);
        for (int i = 1; i < TOTAL; i++) send_pixel(24'($urandom), 1'b1);
        finish_frame(1'b1);
        $display("tb: aborted frame restarted and completed, checksum corrupted");

        repeat (2) @(posedge clk_in);
        #1;
        check("err_sticky_idle", 32'(cksum_err), 32'(CK_EN));
        do_frame_start(1'b0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        sys_rst = 1'b1;
        @(posedge clk_in);
        #1;
        check_reset_outputs("midrst");
        sys_rst = 1'b0;
        @(posedge clk_in);
        #1;
        do_frame_start(1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        check("rst_px_we", 32'(ram_we), 32'd1);
        check("rst_px_addr", 32'(ram_addr), 32'd0);
        check("rst_px_din", 32'(ram_din), 32'h112233);
        @(posedge clk_in);
        #1;
        check("rst_wr_cnt", 32'(wr_cnt), 32'd1);
        $display("tb: reset mid-pixel then fresh pixel at address 0");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
